// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster (vga_x/vga_y, hsync/vsync/video_on, pixel_tick, frame_start) from vga_clk/resetn, plus PIPE_DLY-delayed hsync_d/vsync_d/video_on_d
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 2
) (
  input  logic       vga_clk,
  input  logic       resetn,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       video_on_d
);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [2:0] IDLE     = {~SYNC_POL, ~SYNC_POL, 1'b0};
  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d, vo_q, vo_d, tick_q, fs_q, adv;
  logic [2:0] cur;
  always_comb begin
    adv  = div_q == DIV_LAST;
    div_d = adv ? 4'd0 : div_q + 4'd1;
    x_d  = adv ? (x_q == H_LAST ? 10'd0 : x_q + 10'd1) : x_q;
    y_d  = (adv && x_q == H_LAST) ? (y_q == V_LAST ? 10'd0 : y_q + 10'd1) : y_q;
    hs_d = (x_d >= HS_START && x_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_d = (y_d >= VS_START && y_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    vo_d = x_d < H_ACT && y_d < V_ACT;
  end
  always_ff @(posedge vga_clk or negedge resetn)
    if (!resetn) begin
      div_q  <= 4'd0;
      x_q    <= H_LAST;
      y_q    <= V_LAST;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      vo_q   <= 1'b0;
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vo_q   <= vo_d;
      tick_q <= adv;
      fs_q   <= adv && x_d == 10'd0 && y_d == 10'd0;
    end
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign pixel_tick  = tick_q;
  assign frame_start = fs_q;
  assign cur         = {hs_q, vs_q, vo_q};
  generate
    if (PIPE_DLY == 0) begin : g_comb
      assign {hsync_d, vsync_d, video_on_d} = cur;
    end else begin : g_pipe
      logic [2:0] pipe_q [PIPE_DLY];
      always_ff @(posedge vga_clk or negedge resetn)
        if (!resetn) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= IDLE;
        end else begin
          pipe_q[0] <= cur;
          for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      assign {hsync_d, vsync_d, video_on_d} = pipe_q[PIPE_DLY-1];
    end
  endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with a small raster at CLK_DIV=4/PIPE_DLY=2 and CLK_DIV=1/PIPE_DLY=0
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int P  = HT * VT;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs, vs, vo, tick, fs, hsd, vsd, vod;
  } exp_t;
  logic clk, resetn;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_hs, a_vs, a_vo, a_tick, a_fs, a_hsd, a_vsd, a_vod;
  logic b_hs, b_vs, b_vo, b_tick, b_fs, b_hsd, b_vsd, b_vod;
  int checks = 0, errors = 0, k = 0;
  int la = -1, lb = -1, ll = -1, vcnt = 0;
  bit run = 0;
  exp_t qa[$], qb[$];
  vga_timing_gen #(.CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .PIPE_DLY(2)) u_a (
    .vga_clk(clk), .resetn(resetn), .vga_x(a_x), .vga_y(a_y), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vo), .pixel_tick(a_tick), .frame_start(a_fs), .hsync_d(a_hsd),
    .vsync_d(a_vsd), .video_on_d(a_vod));
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0), .PIPE_DLY(0)) u_b (
    .vga_clk(clk), .resetn(resetn), .vga_x(b_x), .vga_y(b_y), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .pixel_tick(b_tick), .frame_start(b_fs), .hsync_d(b_hsd),
    .vsync_d(b_vsd), .video_on_d(b_vod));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int pos(int n, int div);
    return (P - 1 + (n > 0 ? n / div : 0)) % P;
  endfunction
  function automatic logic hs_of(int p);
    return !((p % HT) >= HA + HF && (p % HT) < HA + HF + HS);
  endfunction
  function automatic logic vs_of(int p);
    return !((p / HT) >= VA + VF && (p / HT) < VA + VF + VS);
  endfunction
  function automatic logic vo_of(int p);
    return (p % HT) < HA && (p / HT) < VA;
  endfunction
  function automatic exp_t model(int n, int div, int dly);
    exp_t e;
    int p, q;
    p = pos(n, div);
    q = pos(n - dly, div);
    e.x = 10'(p % HT);
    e.y = 10'(p / HT);
    e.hs = hs_of(p);
    e.vs = vs_of(p);
    e.vo = vo_of(p);
    e.tick = n > 0 && n % div == 0;
    e.fs = e.tick && p == 0;
    e.hsd = hs_of(q);
    e.vsd = vs_of(q);
    e.vod = vo_of(q);
    return e;
  endfunction
  function automatic exp_t ga();
    return {a_x, a_y, a_hs, a_vs, a_vo, a_tick, a_fs, a_hsd, a_vsd, a_vod};
  endfunction
  function automatic exp_t gb();
    return {b_x, b_y, b_hs, b_vs, b_vo, b_tick, b_fs, b_hsd, b_vsd, b_vod};
  endfunction
  task automatic cmp(input string n, input exp_t g, input exp_t e);
    chk({n, "_x"}, g.x, e.x);
    chk({n, "_y"}, g.y, e.y);
    chk({n, "_hsync"}, g.hs, e.hs);
    chk({n, "_vsync"}, g.vs, e.vs);
    chk({n, "_video_on"}, g.vo, e.vo);
    chk({n, "_tick"}, g.tick, e.tick);
    chk({n, "_frame_start"}, g.fs, e.fs);
    chk({n, "_hsync_d"}, g.hsd, e.hsd);
    chk({n, "_vsync_d"}, g.vsd, e.vsd);
    chk({n, "_video_on_d"}, g.vod, e.vod);
  endtask
  always @(posedge clk)
    if (run) begin
      k++;
      qa.push_back(model(k, 4, 2));
      qb.push_back(model(k, 1, 0));
    end
  always @(negedge clk)
    if (run && qa.size() > 0 && qb.size() > 0) begin
      cmp("a", ga(), qa.pop_front());
      cmp("b", gb(), qb.pop_front());
      if (a_fs) begin
        if (la >= 0) begin
          chk("a_frame_period", k - la, P * 4);
          chk("a_vsync_pixels", vcnt, VS * HT);
        end
        la = k;
        vcnt = 0;
      end
      if (a_tick && !a_vs) vcnt++;
      if (a_tick && a_x == 10'd0) begin
        if (ll >= 0) chk("a_line_period", k - ll, HT * 4);
        ll = k;
      end
      if (b_fs) begin
        if (lb >= 0) chk("b_frame_period", k - lb, P);
        lb = k;
      end
    end
  initial begin
    bit found;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    cmp("rst_a", ga(), model(0, 4, 2));
    cmp("rst_b", gb(), model(0, 1, 0));
    @(posedge clk);
    #2 resetn = 1'b1;
    k = 0;
    run = 1;
    repeat (3300) @(posedge clk);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = a_y == 10'(VA + VF + 1) && a_vs == 1'b0;
    end
    chk("wait_vsync_low", found, 1);
    #2;
    resetn = 1'b0;
    run = 0;
    qa.delete();
    qb.delete();
    la = -1;
    lb = -1;
    ll = -1;
    vcnt = 0;
    #1;
    cmp("midrst_a", ga(), model(0, 4, 2));
    cmp("midrst_b", gb(), model(0, 1, 0));
    repeat (2) @(posedge clk);
    #2;
    cmp("midrst_hold_a", ga(), model(0, 4, 2));
    resetn = 1'b1;
    k = 0;
    run = 1;
    repeat (3200) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA raster that the character renderers and pixel pipeline consume: pixel coordinates vga_x/vga_y, hsync, vsync and video_on.
- Divides vga_clk down to the pixel rate.
- Provides pipeline-delayed copies of the sync and blank signals. These line up with pixel colour produced N vga_clk cycles after the coordinates (char ROM lookup plus output register).

Parameters:
CLK_DIV, 4, vga_clk cycles per pixel (1..16; 100 MHz / 4 = 25 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
PIPE_DLY, 2, vga_clk cycles of delay for the *_d outputs (0..7)

Ports:
vga_clk  input  1  system/pixel clock
resetn  input  1  asynchronous active-low reset
vga_x  output  10  current horizontal position, 0..H_TOTAL-1
vga_y  output  10  current vertical position, 0..V_TOTAL-1
hsync  output  1  horizontal sync, aligned with vga_x/vga_y
vsync  output  1  vertical sync, aligned with vga_x/vga_y
video_on  output  1  1 when vga_x<H_ACTIVE and vga_y<V_ACTIVE
pixel_tick  output  1  one-cycle pulse: first vga_clk cycle of a new pixel
frame_start  output  1  one-cycle pulse coincident with pixel_tick when position becomes (0,0)
hsync_d  output  1  hsync delayed PIPE_DLY cycles
vsync_d  output  1  vsync delayed PIPE_DLY cycles
video_on_d  output  1  video_on delayed PIPE_DLY cycles

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024. All counters and comparisons are 10-bit unsigned.
- Reset (resetn=0, asynchronous):
  - div_cnt=0
  - vga_x=H_TOTAL-1, vga_y=V_TOTAL-1 (last blanking pixel of the frame)
  - hsync=vsync=~SYNC_POL
  - video_on=0, pixel_tick=0, frame_start=0
  - all delay-line stages reset to these same inactive values
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. Internal advance = (div_cnt==CLK_DIV-1). With CLK_DIV=1, advance occurs every cycle.
- On an advance edge:
  - if vga_x==H_TOTAL-1: vga_x<=0; then if vga_y==V_TOTAL-1, vga_y<=0, else vga_y<=vga_y+1
  - otherwise: vga_x<=vga_x+1
  - pixel_tick<=1, else 0
  - frame_start<=1 iff the new position is (0,0)
- hsync, vsync and video_on are registered from the next-position values on the same edge, so they are always consistent with vga_x/vga_y (zero relative latency).
- hsync asserted iff H_ACTIVE+H_FP ≤ vga_x < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync asserted iff V_ACTIVE+V_FP ≤ vga_y < V_ACTIVE+V_FP+V_SYNC (490..491), over whole lines.
- First advance after reset release occurs CLK_DIV cycles after release. It produces (0,0), video_on=1, pixel_tick=1 and frame_start=1.
- *_d outputs: shift register of PIPE_DLY stages clocked every vga_clk, not only on advance. PIPE_DLY=0 makes them combinational copies.
- Frame period: exactly H_TOTAL*V_TOTAL*CLK_DIV vga_clk cycles between frame_start pulses. Line period: H_TOTAL*CLK_DIV.
- Reset asserted mid-frame: all outputs return to reset values immediately, with no partial sync pulse held. Restart follows the post-reset sequence above.
- No other inputs; free-running.

Test Plan:
1. Hold resetn=0, then release → before the first advance: vga_x=799, vga_y=524, hsync=vsync=1, video_on=0. First pixel_tick exactly 4 cycles after release, together with frame_start=1, (0,0) and video_on=1.
2. Run one line at CLK_DIV=4 → hsync falls when vga_x becomes 656 and rises when vga_x becomes 752. video_on falls at vga_x=640. vga_x wraps 799→0 with vga_y incrementing. Line = 3200 cycles.
3. Run a full frame → vsync low only for vga_y 490..491 (1600 pixels). frame_start pulses are exactly 1,680,000 vga_clk cycles apart. vga_y wraps 524→0.
4. CLK_DIV=1 build → pixel_tick high every cycle after release. Frame period is 420,000 cycles.
5. Assert resetn low while vga_y=491 with vsync low → vsync returns high and vga_x/vga_y return to 799/524 in the same cycle, asynchronously. The next frame starts cleanly after release.
6. PIPE_DLY=2 → hsync_d, vsync_d and video_on_d equal hsync, vsync and video_on sampled two vga_clk cycles earlier, checked across a blanking edge at vga_x=640.
